// File: rtl/cic_decimator_pkg.sv
// Shared CIC helpers: the bit-growth rule and the parameter legality check used at
// elaboration.
package cic_decimator_pkg;

    localparam int CIC_MAX_ORDER = 6;
    localparam int CIC_MAX_DIFF_DELAY = 2;

    // ceil(M*log2(D*R)) is evaluated as ceil(log2((D*R)^M)) to stay in integers.
    function automatic int cic_bit_growth(input int in_width, input int m, input int d,
                                          input int r);
        longint gain;
        int bits;
        gain = 1;
        bits = 0;
        for (int unsigned s = 0; s < m; s++) begin
            gain = gain * longint'(d * r);
        end
        while ((longint'(1) << bits) < gain) begin
            bits++;
        end
        return in_width + bits;
    endfunction

    function automatic bit cic_params_legal(input int m, input int d, input int r,
                                            input int in_width, input int out_width);
        return (m >= 1) && (m <= CIC_MAX_ORDER) &&
               (d >= 2) &&
               (r >= 1) && (r <= CIC_MAX_DIFF_DELAY) &&
               (in_width >= 1) && (out_width >= in_width);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: output = input minus the input seen R decimated samples ago.
module cic_comb_stage
    import cic_decimator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int R     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] dout
);

    logic signed [WIDTH-1:0] dly [R];

    assign dout = din - dly[R-1];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < R; i++) begin
                dly[i] <= '0;
            end
        end else if (en) begin
            dly[0] <= din;
            for (int unsigned i = 1; i < R; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator: M pipelined integrators at the input rate, M combs at the decimated
// rate, registered output with a one-cycle clk_transfer strobe per decimated sample.
module cic_decimator
    import cic_decimator_pkg::*;
#(
    parameter int M         = 1,
    parameter int D         = 5,
    parameter int R         = 1,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enabled,
    input  logic signed [IN_WIDTH-1:0]  x,
    output logic                        clk_transfer,
    output logic signed [OUT_WIDTH-1:0] y
);

    localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
    localparam int REQ_W = cic_bit_growth(IN_WIDTH, M, D, R);

    if (!cic_params_legal(M, D, R, IN_WIDTH, OUT_WIDTH)) begin : g_illegal_params
        $fatal(1, "cic_decimator: illegal M/D/R/IN_WIDTH/OUT_WIDTH combination");
    end
    if (OUT_WIDTH < REQ_W) begin : g_width_too_small
        $fatal(1, "cic_decimator: OUT_WIDTH too small for the CIC bit growth");
    end

    logic signed [OUT_WIDTH-1:0] x_ext;
    logic signed [OUT_WIDTH-1:0] integ [M];
    logic        [CNT_W-1:0]     cnt;
    logic                        dec_pend;
    logic                        window_done;
    logic signed [OUT_WIDTH-1:0] comb_io [M+1];

    assign x_ext       = OUT_WIDTH'(x);
    assign window_done = enabled && (cnt == CNT_W'(D - 1));

    // Each integrator adds the pre-edge value of its predecessor, so the chain is
    // pipelined and adds M-1 input samples of latency in front of the CIC response.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned k = 0; k < M; k++) begin
                integ[k] <= '0;
            end
            cnt      <= '0;
            dec_pend <= 1'b0;
        end else begin
            dec_pend <= window_done;
            if (enabled) begin
                integ[0] <= integ[0] + x_ext;
                for (int unsigned k = 1; k < M; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                cnt <= window_done ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    assign comb_io[0] = integ[M-1];

    for (genvar k = 0; k < M; k++) begin : g_comb
        cic_comb_stage #(
            .WIDTH (OUT_WIDTH),
            .R     (R)
        ) u_comb (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (dec_pend),
            .din   (comb_io[k]),
            .dout  (comb_io[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            y            <= '0;
            clk_transfer <= 1'b0;
        end else begin
            clk_transfer <= dec_pend;
            if (dec_pend) begin
                y <= comb_io[M];
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: a default instance and an M=3/D=4 instance share stimulus
// and are compared against an impulse-response convolution model every cycle.
module tb_cic_decimator;

    localparam int IW  = 12;
    localparam int OW0 = 16;
    localparam int OW1 = 20;

    typedef longint lq_t[$];

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enabled;
    logic signed [IW-1:0]  x;
    logic                  tr0, tr1;
    logic signed [OW0-1:0] y0;
    logic signed [OW1-1:0] y1;

    cic_decimator #(.M(1), .D(5), .R(1), .IN_WIDTH(IW), .OUT_WIDTH(OW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .x(x),
        .clk_transfer(tr0), .y(y0)
    );

    cic_decimator #(.M(3), .D(4), .R(1), .IN_WIDTH(IW), .OUT_WIDTH(OW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .x(x),
        .clk_transfer(tr1), .y(y1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    lq_t h0, h1;
    int  q[$];
    int  n_in;
    bit  due0, due1, et0, et1;
    logic signed [OW0-1:0] ey0;
    logic signed [OW1-1:0] ey1;

    // (sum_{i<dr} z^-i)^m, preceded by m-1 zero taps for the pipelined integrators.
    function automatic lq_t cic_taps(input int m, input int dr);
        lq_t h, t;
        h = {};
        for (int i = 0; i < m - 1; i++) h.push_back(0);
        h.push_back(1);
        for (int s = 0; s < m; s++) begin
            t = {};
            for (int i = 0; i < h.size() + dr - 1; i++) t.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < dr; j++) t[i+j] = t[i+j] + h[i];
            h = t;
        end
        return h;
    endfunction

    function automatic longint cic_ref(input lq_t h);
        longint acc;
        acc = 0;
        for (int j = 0; j < h.size() && j < q.size(); j++)
            acc += h[j] * longint'(q[q.size()-1-j]);
        return acc;
    endfunction

    task automatic drive(input logic r, input logic e, input logic signed [IW-1:0] xv);
        rst_n = r;
        enabled = e;
        x = xv;
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            n_in = 0;
            due0 = 0; due1 = 0; et0 = 0; et1 = 0;
            ey0 = '0; ey1 = '0;
        end else begin
            et0 = due0;
            et1 = due1;
            if (due0) ey0 = OW0'(cic_ref(h0));
            if (due1) ey1 = OW1'(cic_ref(h1));
            due0 = 0;
            due1 = 0;
            if (e) begin
                q.push_back(int'(xv));
                if (q.size() > 32) void'(q.pop_front());
                n_in++;
                due0 = (n_in % 5 == 0);
                due1 = (n_in % 4 == 0);
            end
        end
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, IW'(1000));
            n_vec++;
            if ({tr0, y0, tr1, y1} !== {1'b0, OW0'(0), 1'b0, OW1'(0)}) begin
                n_err++;
                $display("FAIL reset cyc=%0d got tr0=%b y0=%0d tr1=%b y1=%0d want all 0",
                         cyc, tr0, y0, tr1, y1);
            end
        end
    endtask

    task automatic test_impulse;
        int pulses, hits, last;
        pulses = 0; hits = 0; last = -1;
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 41; i++) begin
            drive(1'b0, 1'b1, (i == 0) ? IW'(1000) : IW'(0));
            n_vec++;
            if ({tr0, y0, tr1, y1} !== {et0, ey0, et1, ey1}) begin
                n_err++;
                $display("FAIL impulse cyc=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d",
                         cyc, tr0, y0, tr1, y1, et0, ey0, et1, ey1);
            end
            if (tr0) begin
                pulses++;
                if (y0 == 1000) hits++;
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last !== 5) begin
                        n_err++;
                        $display("FAIL impulse_spacing got %0d want 5", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_vec++;
        if (pulses !== 8 || hits !== 1) begin
            n_err++;
            $display("FAIL impulse_count got pulses=%0d hits=%0d want 8 1", pulses, hits);
        end
    endtask

    task automatic test_dc;
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'b1, IW'(1));
            n_vec++;
            if ({tr0, y0, tr1, y1} !== {et0, ey0, et1, ey1}) begin
                n_err++;
                $display("FAIL dc cyc=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d",
                         cyc, tr0, y0, tr1, y1, et0, ey0, et1, ey1);
            end
        end
        n_vec++;
        if (y0 !== OW0'(5) || y1 !== OW1'(64)) begin
            n_err++;
            $display("FAIL dc_settle got y0=%0d y1=%0d want 5 64", y0, y1);
        end
    endtask

    task automatic test_full_scale;
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 5005; i++) begin
            drive(1'b0, 1'b1, IW'(-2048));
            n_vec++;
            if ({tr0, y0, tr1, y1} !== {et0, ey0, et1, ey1}) begin
                n_err++;
                $display("FAIL full_scale cyc=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d",
                         cyc, tr0, y0, tr1, y1, et0, ey0, et1, ey1);
            end
        end
        n_vec++;
        if (y0 !== OW0'(-10240) || y1 !== OW1'(-131072)) begin
            n_err++;
            $display("FAIL full_scale_final got y0=%0d y1=%0d want -10240 -131072", y0, y1);
        end
    endtask

    task automatic test_gating;
        int last;
        last = -1;
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, (i % 2 == 0), IW'(1));
            n_vec++;
            if ({tr0, y0, tr1, y1} !== {et0, ey0, et1, ey1}) begin
                n_err++;
                $display("FAIL gating cyc=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d",
                         cyc, tr0, y0, tr1, y1, et0, ey0, et1, ey1);
            end
            if (tr0) begin
                n_vec++;
                if (y0 !== OW0'(5) || (last >= 0 && cyc - last != 10)) begin
                    n_err++;
                    $display("FAIL gating_pulse got y0=%0d gap=%0d want 5 10", y0, cyc - last);
                end
                last = cyc;
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, IW'(100));
        drive(1'b1, 1'b1, IW'(100));
        n_vec++;
        if (y0 !== OW0'(0) || tr0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_clear got tr0=%b y0=%0d want 0 0", tr0, y0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, IW'(100));
            n_vec++;
            if ({tr0, y0, tr1, y1} !== {et0, ey0, et1, ey1}) begin
                n_err++;
                $display("FAIL reset_mid cyc=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d",
                         cyc, tr0, y0, tr1, y1, et0, ey0, et1, ey1);
            end
        end
        drive(1'b0, 1'b0, '0);
        n_vec++;
        if (tr0 !== 1'b1 || y0 !== OW0'(500)) begin
            n_err++;
            $display("FAIL reset_mid_window got tr0=%b y0=%0d want 1 500", tr0, y0);
        end
    endtask

    task automatic test_random;
        logic r, e;
        logic signed [IW-1:0] xv;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 200 == 0);
            e = ($urandom % 4 != 0);
            case ($urandom % 8)
                0: xv = IW'(-2048);
                1: xv = IW'(2047);
                default: xv = IW'($urandom);
            endcase
            drive(r, e, xv);
            n_vec++;
            if ({tr0, y0, tr1, y1} !== {et0, ey0, et1, ey1}) begin
                n_err++;
                $display("FAIL random cyc=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d",
                         cyc, tr0, y0, tr1, y1, et0, ey0, et1, ey1);
            end
        end
    endtask

    initial begin
        h0 = cic_taps(1, 5);
        h1 = cic_taps(3, 4);
        rst_n = 1'b1;
        enabled = 1'b0;
        x = '0;
        @(negedge clk);
        test_reset;
        test_impulse;
        test_dc;
        test_full_scale;
        test_gating;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
